// File: rtl/ysyx_24070016_pkg.sv
// Shared constants for the key table: default geometry and the key+data pair width helper.
package ysyx_24070016_pkg;

    localparam int NR_KEY_DEF   = 4;
    localparam int KEY_LEN_DEF  = 4;
    localparam int DATA_LEN_DEF = 32;

    function automatic int pairLen(input int keyLen, input int dataLen);
        return keyLen + dataLen;
    endfunction

    localparam int PAIR_LEN = pairLen(KEY_LEN_DEF, DATA_LEN_DEF);

endpackage

// File: rtl/ysyx_24070016_pri_enc.sv
// Lowest-index-first priority encoder: one-hot grant of the first set request bit.
module ysyx_24070016_pri_enc #(
    parameter int N = 4
) (
    input  logic [N-1:0] req_i,
    output logic [N-1:0] grant_o,
    output logic         anyFree_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (req_i[i] && !found) begin
                grant_o[i] = 1'b1;
                found      = 1'b1;
            end
        end
    end

    assign anyFree_o = |req_i;

endmodule

// File: rtl/ysyx_24070016_key_table.sv
// Small associative key/data table with registered lookup and packed table export.
// Define YSYX_24070016_KEYTAB_BYPASS_EN to forward same-cycle writes/clr into lookups.
module ysyx_24070016_key_table
    import ysyx_24070016_pkg::*;
#(
    parameter int NR_KEY   = NR_KEY_DEF,
    parameter int KEY_LEN  = KEY_LEN_DEF,
    parameter int DATA_LEN = DATA_LEN_DEF
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   wr_valid,
    output logic                                   wr_ready,
    input  logic [KEY_LEN-1:0]                     wr_key,
    input  logic [DATA_LEN-1:0]                    wr_data,
    input  logic                                   clr,
    input  logic                                   lk_valid,
    input  logic [KEY_LEN-1:0]                     lk_key,
    output logic                                   rsp_valid,
    output logic                                   rsp_hit,
    output logic [DATA_LEN-1:0]                    rsp_data,
    output logic [$clog2(NR_KEY+1)-1:0]            count,
    output logic                                   full,
    output logic [NR_KEY*(KEY_LEN+DATA_LEN)-1:0]   lut
);

    localparam int PAIR = pairLen(KEY_LEN, DATA_LEN);
    localparam int CW   = $clog2(NR_KEY+1);

    logic [KEY_LEN-1:0]  entryKey_q  [NR_KEY];
    logic [KEY_LEN-1:0]  entryKey_d  [NR_KEY];
    logic [DATA_LEN-1:0] entryData_q [NR_KEY];
    logic [DATA_LEN-1:0] entryData_d [NR_KEY];
    logic [NR_KEY-1:0]   valid_q, valid_d;
    logic [CW-1:0]       count_q, count_d;
    logic                rspValid_q, rspHit_q;
    logic [DATA_LEN-1:0] rspData_q;

    logic [NR_KEY-1:0]   wrMatch, lkMatch, freeGrant;
    logic                anyWrMatch, anyFree, wrFire;
    logic                tblHit, lkHit_d;
    logic [DATA_LEN-1:0] tblData, lkData_d;

    always_comb begin
        for (int i = 0; i < NR_KEY; i++) begin
            wrMatch[i] = valid_q[i] && (entryKey_q[i] == wr_key);
            lkMatch[i] = valid_q[i] && (entryKey_q[i] == lk_key);
        end
    end

    assign anyWrMatch = |wrMatch;
    assign full       = (count_q == CW'(NR_KEY));
    assign count      = count_q;
    assign wr_ready   = !clr && (!full || anyWrMatch);
    assign wrFire     = wr_valid && wr_ready;

    ysyx_24070016_pri_enc #(.N(NR_KEY)) u_pri_enc (
        .req_i     (~valid_q),
        .grant_o   (freeGrant),
        .anyFree_o (anyFree)
    );

    // A matching key is always updated in place so no key can occupy two entries.
    always_comb begin
        valid_d     = valid_q;
        entryKey_d  = entryKey_q;
        entryData_d = entryData_q;
        count_d     = count_q;
        if (clr) begin
            valid_d = '0;
            count_d = '0;
            for (int i = 0; i < NR_KEY; i++) begin
                entryKey_d[i]  = '0;
                entryData_d[i] = '0;
            end
        end else if (wrFire) begin
            if (anyWrMatch) begin
                for (int i = 0; i < NR_KEY; i++) begin
                    if (wrMatch[i]) entryData_d[i] = wr_data;
                end
            end else if (anyFree) begin
                for (int i = 0; i < NR_KEY; i++) begin
                    if (freeGrant[i]) begin
                        valid_d[i]     = 1'b1;
                        entryKey_d[i]  = wr_key;
                        entryData_d[i] = wr_data;
                    end
                end
                count_d = count_q + CW'(1);
            end
        end
    end

    always_comb begin
        tblData = '0;
        for (int i = 0; i < NR_KEY; i++) begin
            if (lkMatch[i]) tblData = tblData | entryData_q[i];
        end
        tblHit = |lkMatch;
    end

`ifdef YSYX_24070016_KEYTAB_BYPASS_EN
    always_comb begin
        lkHit_d  = tblHit;
        lkData_d = tblData;
        if (clr) begin
            lkHit_d  = 1'b0;
            lkData_d = '0;
        end else if (wrFire && (wr_key == lk_key)) begin
            lkHit_d  = 1'b1;
            lkData_d = wr_data;
        end
    end
`else
    always_comb begin
        lkHit_d  = tblHit;
        lkData_d = tblData;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= '0;
            count_q    <= '0;
            rspValid_q <= 1'b0;
            rspHit_q   <= 1'b0;
            rspData_q  <= '0;
            for (int i = 0; i < NR_KEY; i++) begin
                entryKey_q[i]  <= '0;
                entryData_q[i] <= '0;
            end
        end else begin
            valid_q     <= valid_d;
            count_q     <= count_d;
            entryKey_q  <= entryKey_d;
            entryData_q <= entryData_d;
            rspValid_q  <= lk_valid;
            rspHit_q    <= lk_valid && lkHit_d;
            rspData_q   <= lk_valid ? lkData_d : '0;
        end
    end

    assign rsp_valid = rspValid_q;
    assign rsp_hit   = rspHit_q;
    assign rsp_data  = rspData_q;

    // Invalid slots export zeros so a downstream OR-reduction mux stays clean.
    always_comb begin
        lut = '0;
        for (int n = 0; n < NR_KEY; n++) begin
            lut[n*PAIR +: PAIR] = valid_q[n] ? {entryKey_q[n], entryData_q[n]} : {PAIR{1'b0}};
        end
    end

endmodule
